// File: rtl/spi_pkg.sv
// Shared definitions for the SPI initiator: command layout, opcodes and FSM state type.
package spi_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_MODE,
    ST_SHIFT,
    ST_RD_WAIT,
    ST_RD_SHIFT,
    ST_RESP,
    ST_GAP
  } spi_state_t;

  // Only a read-data command keeps the slave selected to return a byte.
  function automatic spi_state_t state_after_cmd(input logic [1:0] op);
    spi_state_t nxt;
    nxt = ST_GAP;
    case (op)
      OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR: nxt = ST_GAP;
      OP_RD_DATA:                         nxt = ST_RD_WAIT;
      default:                            nxt = ST_GAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// MSB-first shift register with parallel load; serial output is q[W-1], serial input enters at bit 0.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         ser_in,
  output logic [W-1:0] q
);

  // Pure datapath: contents are only meaningful after a load or a full shift sequence.
  always_ff @(posedge clk) begin
    if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[W-2:0], ser_in};
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator: frames a 10-bit host command on SS_n/MOSI and, for read-data commands,
// captures the 8-bit reply from MISO. Outputs lag the state register by one edge.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int RD_WAIT = 2,
  parameter int GAP     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd_data,
  output logic             cmd_ready,
  output logic             rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic             busy,
  output logic             SS_n,
  output logic             MOSI,
  input  logic             MISO
);

  localparam logic [3:0] CMD_MSB   = 4'(CMD_W - 1);
  localparam logic [3:0] RX_LAST   = 4'(DATA_W - 1);
  localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

  spi_state_t        state;
  logic [3:0]        cnt;
  logic [1:0]        op_q;
  logic [CMD_W-1:0]  cmd_q;
  logic [DATA_W-1:0] shift_q;
  logic              cmd_load;
  logic              rx_shift;

  assign cmd_load = (state == ST_IDLE) && cmd_valid && cmd_ready;
  assign rx_shift = (state == ST_RD_SHIFT);

  // Command word is frozen at accept; later cmd_data changes cannot reach the frame.
  spi_shift_reg #(.W(CMD_W)) u_cmd_sr (
    .clk       (clk),
    .load      (cmd_load),
    .load_data (cmd_data),
    .shift_en  (1'b0),
    .ser_in    (1'b0),
    .q         (cmd_q)
  );

  spi_shift_reg #(.W(DATA_W)) u_rx_sr (
    .clk       (clk),
    .load      (1'b0),
    .load_data ('0),
    .shift_en  (rx_shift),
    .ser_in    (MISO),
    .q         (shift_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          SS_n <= 1'b1;
          MOSI <= 1'b0;
          cnt  <= '0;
          if (cmd_load) begin
            op_q      <= cmd_data[CMD_W-1 -: 2];
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_START;
          end else begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        ST_START: begin
          SS_n  <= 1'b0;
          MOSI  <= 1'b0;
          state <= ST_MODE;
        end
        ST_MODE: begin
          MOSI  <= cmd_q[CMD_MSB];
          cnt   <= '0;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          MOSI <= cmd_q[CMD_MSB - cnt];
          if (cnt == CMD_MSB) begin
            cnt   <= '0;
            state <= state_after_cmd(op_q);
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_RD_WAIT: begin
          SS_n <= 1'b0;
          MOSI <= 1'b0;
          if (cnt == WAIT_LAST) begin
            cnt   <= '0;
            state <= ST_RD_SHIFT;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_RD_SHIFT: begin
          SS_n <= 1'b0;
          MOSI <= 1'b0;
          if (cnt == RX_LAST) begin
            cnt   <= '0;
            state <= ST_RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_RESP: begin
          SS_n      <= 1'b0;
          MOSI      <= 1'b0;
          rsp_data  <= shift_q;
          rsp_valid <= 1'b1;
          state     <= ST_GAP;
        end
        ST_GAP: begin
          SS_n <= 1'b1;
          MOSI <= 1'b0;
          if (cnt == GAP_LAST) begin
            cnt       <= '0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: frame-level reference model plus directed and random commands.
module tb_spi_master_ctrl;

  localparam int RDW = 4;
  localparam int GP  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_data = '0;
  logic       MISO = 1'b0;
  logic       cmd_ready, rsp_valid, busy, SS_n, MOSI;
  logic [7:0] rsp_data;

  always #5 clk = ~clk;

  spi_master_ctrl #(.RD_WAIT(RDW), .GAP(GP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: a frame is described by its accept cycle, word and length;
  // expected pins are read off the frame timeline relative to the accept edge.
  bit         model_ok = 0, active = 0, rst_edge = 0, m_read = 0, ready_prev = 0;
  int         t0 = 0, endc = 0, acc_cyc = -1, mk = 0;
  logic [9:0] m_word = '0;
  logic [7:0] m_byte = '0, slave_next = '0;
  logic       e_ss = 1'b1, e_mosi = 1'b0, e_ready = 1'b0, e_busy = 1'b0, e_rv = 1'b0;
  logic [7:0] e_rdata = '0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      model_ok = 1; active = 0; rst_edge = 1; e_rdata = '0;
    end else begin
      rst_edge = 0;
      if (active && cyc >= endc) active = 0;
      if (!active && cmd_valid && ready_prev) begin
        active = 1; t0 = cyc; acc_cyc = cyc;
        m_word = cmd_data; m_byte = slave_next;
        m_read = (cmd_data[9:8] == 2'b11);
        endc = m_read ? cyc + 21 + RDW + GP : cyc + 12 + GP;
      end
    end
    mk = cyc - t0;
    e_rv = 1'b0;
    if (rst_edge || !active) begin
      e_ss = 1'b1; e_mosi = 1'b0; e_busy = 1'b0; e_ready = !rst_edge;
    end else begin
      e_busy = 1'b1; e_ready = 1'b0;
      e_ss = (mk >= 1 && mk <= (m_read ? 21 + RDW : 12)) ? 1'b0 : 1'b1;
      if (mk == 2) e_mosi = m_word[9];
      else if (mk >= 3 && mk <= 12) e_mosi = m_word[12 - mk];
      else e_mosi = 1'b0;
      if (m_read && mk == 21 + RDW) begin
        e_rv = 1'b1; e_rdata = m_byte;
      end
    end
    ready_prev = e_ready;
  end

  // Slave: presents the reply byte MSB first on the sampling edges, noise elsewhere.
  initial forever begin
    int e;
    @(posedge clk); #1;
    e = cyc + 1 - t0;
    if (active && m_read && e >= 13 + RDW && e <= 20 + RDW) MISO = m_byte[7 - (e - 13 - RDW)];
    else MISO = 1'($urandom);
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("SS_n", 32'(SS_n), 32'(e_ss));
      chk("MOSI", 32'(MOSI), 32'(e_mosi));
      chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("rsp_data", 32'(rsp_data), 32'(e_rdata));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [9:0] w, input logic [7:0] b, output int t);
    slave_next = b; cmd_valid = 1'b1; cmd_data = w; t = -1;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (acc_cyc == cyc) begin t = cyc; break; end
    end
    cmd_valid = 1'b0; cmd_data = 10'($urandom);
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL accept_timeout: word %0h never accepted, required within 200 cycles", w);
    end
  endtask

  task automatic cap_frame(output logic [10:0] bits);
    bits = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k >= 2) bits = {bits[9:0], MOSI};
    end
  endtask

  task automatic wait_rsp(input int t, output int dt, output logic [7:0] d);
    dt = -1; d = '0;
    for (int n = 0; n < 100; n++) begin
      if (rsp_valid) begin dt = cyc - t; d = rsp_data; break; end
      tick();
    end
    if (dt < 0) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: no rsp_valid, required within 100 cycles");
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200 && !e_ready; n++) tick();
  endtask

  initial begin
    int t1, t2, dt;
    logic [10:0] bits;
    logic [7:0] d;

    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_SS_n", 32'(SS_n), 32'd1);
    rst_n = 1'b1;

    // Write address 0x0A5: MODE bit then ten command bits.
    send(10'h0A5, 8'h00, t1);
    cap_frame(bits);
    chk("wa_bits", 32'(bits), 32'b00010100101);
    tick();
    chk("wa_ss_rise", 32'(SS_n), 32'd1);
    for (int n = 0; n < 50 && !cmd_ready; n++) tick();
    chk("wa_ready_lat", 32'(cyc - t1), 32'd14);

    // Read address, then read data with reply 0xC3 at T+21+RD_WAIT.
    send(10'h23C, 8'h11, t1);
    wait_idle();
    send(10'h300, 8'hC3, t1);
    tick(); tick();
    chk("rd_mode_bit", 32'(MOSI), 32'd1);
    wait_rsp(t1, dt, d);
    chk("rd_lat", 32'(dt), 32'd25);
    chk("rd_data_c3", 32'(d), 32'hC3);

    send(10'h3FF, 8'h81, t1);
    wait_rsp(t1, dt, d);
    chk("rd_lat_81", 32'(dt), 32'd25);
    chk("rd_data_81", 32'(d), 32'h81);

    // cmd_valid held with a changing word: only words seen at IDLE are taken.
    slave_next = 8'($urandom);
    cmd_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      cmd_data = 10'($urandom);
      tick();
    end
    cmd_valid = 1'b0;
    wait_idle();

    // Reset while SHIFT is on bit 5 (edge T+8), then a clean frame.
    send(10'h3AA, 8'h5A, t1);
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_ss", 32'(SS_n), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    send(10'h155, 8'h00, t1);
    cap_frame(bits);
    chk("post_rst_bits", 32'(bits), 32'b00101010101);
    wait_idle();

    // Back-to-back writes: next accept 12 + GAP + 1 cycles later.
    send(10'h1FF, 8'h00, t1);
    cap_frame(bits);
    chk("b2b_a_bits", 32'(bits), 32'b00111111111);
    send(10'h100, 8'h00, t2);
    chk("b2b_spacing", 32'(t2 - t1), 32'd15);
    cap_frame(bits);
    chk("b2b_b_bits", 32'(bits), 32'b00100000000);

    // Random commands with occasional resets mid-frame.
    for (int i = 0; i < 150; i++) begin
      send({2'($urandom), 8'($urandom)}, 8'($urandom), t1);
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 30)) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        repeat ($urandom_range(0, 20)) tick();
      end
    end
    wait_idle();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
